// File: rtl/nibble_fifo.sv
// nibble_fifo: synchronous single-clock FIFO with a registered pop port.
// A pop loads dout on the sampling edge, so dout and dout_valid appear one cycle
// after rd_en. A full FIFO takes a push when a pop happens on the same edge.
// Rejected requests leave pointers, count and storage unchanged, and they
// produce a one-cycle overflow or underflow pulse.
module nibble_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Storage is deliberately not reset; a reset empties the FIFO by clearing pointers and count.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic             full_w;
    logic             empty_w;
    logic             pop_acc;
    logic             push_acc;

    // Flags come only from registered count, so wr_en and rd_en have no combinational path to them.
    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    // A pop frees a slot on a full FIFO, so a push on the same edge is still accepted.
    assign pop_acc  = rd_en && !empty_w;
    assign push_acc = wr_en && (!full_w || pop_acc);

    // Compute next values for the pointers, count and output data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write storage on an accepted push. The write is also gated while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && push_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Update the control state and the registered outputs; asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= pop_acc;
            overflow_q   <= wr_en && !push_acc;
            underflow_q  <= rd_en && empty_w;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_nibble_fifo.sv
// tb_nibble_fifo: directed test of nibble_fifo. The expected values are computed by hand.
// Inputs change 1ns after a rising edge, and outputs are sampled at that same point.
module tb_nibble_fifo;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] din;
    logic       rd_en;
    logic [3:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    nibble_fifo #(.WIDTH(4), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        wr_en = 1'b1; din = d; rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop_exp(input string tag, input logic [3:0] d);
        rd_en = 1'b1; wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
        chk({tag, "_dout"}, 32'(dout), 32'(d));
        chk({tag, "_vld"}, 32'(dout_valid), 32'd1);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 4'h0;
        tick(); tick();
        reset = 1'b1;
        tick();

        // Put one entry through, then apply reset between edges.
        push(4'h5);
        pop_exp("pre", 4'h5);
        push(4'h6);
        #2 reset = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_vld", 32'(dout_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);
        // Requests are ignored while reset is asserted.
        wr_en = 1'b1; rd_en = 1'b1; din = 4'h9;
        tick();
        chk("rst_ign_count", 32'(count), 32'd0);
        wr_en = 1'b0; rd_en = 1'b0;
        reset = 1'b1;

        // Fill and drain.
        for (int i = 1; i <= 4; i++) begin
            push(4'(i));
            chk("fill_count", 32'(count), 32'(i));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);

        // Overflow while full.
        push(4'hE);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        tick();
        chk("ovf_clear", 32'(overflow), 32'd0);

        pop_exp("drain1", 4'h1);
        pop_exp("drain2", 4'h2);
        pop_exp("drain3", 4'h3);
        pop_exp("drain4", 4'h4);
        chk("drain_empty", 32'(empty), 32'd1);
        tick();
        chk("vld_drop", 32'(dout_valid), 32'd0);
        chk("hold_dout", 32'(dout), 32'h4);

        // Underflow while empty.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("unf_pulse", 32'(underflow), 32'd1);
        chk("unf_dout", 32'(dout), 32'h4);
        chk("unf_vld", 32'(dout_valid), 32'd0);
        tick();
        chk("unf_clear", 32'(underflow), 32'd0);

        // Push and pop on the same edge while full.
        for (int i = 1; i <= 4; i++) push(4'(i));
        wr_en = 1'b1; rd_en = 1'b1; din = 4'hA;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("simf_dout", 32'(dout), 32'h1);
        chk("simf_count", 32'(count), 32'd4);
        chk("simf_ovf", 32'(overflow), 32'd0);
        pop_exp("simf_d2", 4'h2);
        pop_exp("simf_d3", 4'h3);
        pop_exp("simf_d4", 4'h4);
        pop_exp("simf_dA", 4'hA);
        chk("simf_empty", 32'(empty), 32'd1);

        // Push and pop on the same edge while empty: only the push is accepted.
        wr_en = 1'b1; rd_en = 1'b1; din = 4'h7;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("sime_count", 32'(count), 32'd1);
        chk("sime_unf", 32'(underflow), 32'd1);
        chk("sime_vld", 32'(dout_valid), 32'd0);
        pop_exp("sime_pop", 4'h7);
        chk("sime_empty", 32'(empty), 32'd1);

        // Interleave pushes and pops so the pointers wrap.
        push(4'h8);
        push(4'h9);
        pop_exp("wrap_8", 4'h8);
        pop_exp("wrap_9", 4'h9);
        push(4'hB);
        push(4'hC);
        push(4'hD);
        pop_exp("wrap_B", 4'hB);
        pop_exp("wrap_C", 4'hC);
        pop_exp("wrap_D", 4'hD);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Reset with three entries stored discards them.
        push(4'h1);
        push(4'h2);
        push(4'h3);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        tick();
        reset = 1'b1;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post_rst_unf", 32'(underflow), 32'd1);
        chk("post_rst_vld", 32'(dout_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_fifo.md
NIBBLE_FIFO -- requirements
Module: nibble_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of storage entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: push request.
REQ-006 The block SHALL have port din, input, WIDTH bits: push data, sampled with wr_en.
REQ-007 The block SHALL have port rd_en, input, 1 bit: pop request.
REQ-008 The block SHALL have port dout, output, WIDTH bits: registered pop data.
REQ-009 The block SHALL have port dout_valid, output, 1 bit: high for exactly one cycle when dout carries newly popped data.
REQ-010 The block SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-011 The block SHALL have port empty, output, 1 bit: high when count equals 0.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1 bits: number of stored entries.
REQ-013 The block SHALL have port overflow, output, 1 bit: one-cycle pulse on a rejected push.
REQ-014 The block SHALL have port underflow, output, 1 bit: one-cycle pulse on a rejected pop.

Function
REQ-015 Pop accepted SHALL be defined as rd_en AND NOT empty; the pre-edge state is used.
REQ-016 Push accepted SHALL be defined as wr_en AND (NOT full OR pop accepted).
REQ-017 An accepted push SHALL write din to the entry at wr_ptr, and wr_ptr SHALL advance by 1 modulo DEPTH.
REQ-018 An accepted pop SHALL load dout with the entry at rd_ptr on the same edge, rd_ptr SHALL advance by 1 modulo DEPTH, and dout_valid SHALL be 1 in the following cycle.
REQ-019 Read latency SHALL be 1 cycle, measured from the rd_en sampling edge to dout/dout_valid.
REQ-020 dout SHALL hold its last value when no pop is accepted, while dout_valid is 0.
REQ-021 count SHALL change as follows: +1 on push only; -1 on pop only; unchanged when both or neither are accepted.
REQ-022 Simultaneous push and pop when empty SHALL accept only the push; count becomes 1 and underflow pulses.
REQ-023 Simultaneous push and pop when full SHALL accept both; count stays DEPTH, and dout receives the oldest entry.
REQ-024 overflow SHALL be 1 in the cycle after an edge where wr_en=1 and the push was not accepted.
REQ-025 underflow SHALL be 1 in the cycle after an edge where rd_en=1 and empty=1.
REQ-026 Rejected requests SHALL NOT alter pointers, count or storage.
REQ-027 full and empty SHALL be derived from registered count with no combinational path from wr_en or rd_en.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with data order preserved (FIFO order).

Reset
REQ-029 When reset=0, the block SHALL immediately force, independent of clk: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, dout=0, dout_valid=0, overflow=0, underflow=0.
REQ-030 Storage contents SHALL NOT be reset, and a reset asserted mid-operation SHALL discard all stored entries.
REQ-031 While reset=0, wr_en and rd_en SHALL be ignored.
REQ-032 The first accepted operation SHALL occur on the first rising edge after reset deasserts to 1.

Verification
REQ-033 Reset test: assert reset=0 between clock edges -> outputs take their reset values immediately, with count=0, empty=1, dout=4'h0.
REQ-034 Fill and drain test: push 4'h1, 4'h2, 4'h3, 4'h4 -> full=1 and count=4; then pop 4 times -> dout sequence is 1, 2, 3, 4, each 1 cycle after rd_en, ending with empty=1.
REQ-035 Overflow/underflow test: while full, push 4'hE -> overflow pulses for 1 cycle and count stays 4; drain, then pop while empty -> underflow pulses, dout holds 4'h4, dout_valid=0.
REQ-036 Simultaneous full test: with full, hold wr_en=rd_en=1 and din=4'hA -> dout=4'h1, count stays 4, and 4'hA is later popped last.
REQ-037 Simultaneous empty test: with empty, hold wr_en=rd_en=1 and din=4'h7 -> count=1, underflow=1, and the next pop returns 4'h7.
REQ-038 Wrap and reset test: perform 10 interleaved push/pop operations across the pointer wrap -> FIFO order is preserved; then apply reset=0 with count=3 -> count=0, and the next pop yields underflow.
